seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Memory-mapped multi-digit 7-segment display controller for the alarm-clock SoC; the parametrised successor to the single-digit segment PIO.
- Drives NUM_DIGITS displays in parallel from one slave.
- Per-digit raw-pattern or hex-decode mode, per-digit blink from a prescaled phase counter, global display enable, optional active-low drive.
- Sits on the processor data bus next to the timer and key PIOs.

Parameters:
- NUM_DIGITS, 6, number of digits (1..8).
- SEG_W, 7, segments per digit (7, or 8 to include the decimal point).
- ADDR_W, 4, word-address width; must cover NUM_DIGITS+2.
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
- ACTIVE_LOW, 1, 1 = a lit segment is driven 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- seg_out  out  NUM_DIGITS*SEG_W  segment drives; digit i occupies [i*SEG_W +: SEG_W].
- blink_phase  out  1  current blink phase (1 = blinking digits dark).

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
- Register map (word addresses):
  - 0..NUM_DIGITS-1 DIGIT[i]: stores writedata[SEG_W-1:0]; reset 0.
  - NUM_DIGITS CTRL, read/write:
    - [7:0] decode mask; bit i = digit i shown as hex.
    - [15:8] blink mask.
    - [16] display enable.
    - Reset: decode 0, blink 0, enable 1. Mask bits >= NUM_DIGITS are stored as 0 and read as 0.
  - NUM_DIGITS+1 STATUS, read-only: [0] blink_phase. Writes are ignored.
  - Any other address reads 0; writes to it are ignored.
- readdata returns the register contents zero-extended to 32 bits, in the same cycle as the address.
- Hex decode: digit bits [3:0] map to the standard 0-F patterns (seg bit0 = a ... bit6 = g).
  - 0 = 0x3F, 1 = 0x06, 8 = 0x7F, A = 0x77, F = 0x71 (active-high values).
  - With SEG_W=8: dp = digit bit 4 in decode mode; in raw mode dp = digit bit 7.
- Pixel logic per digit, active-high before polarity:
  - lit = enable & ~(blink[i] & blink_phase).
  - pattern = decode[i] ? hex(d[3:0]) : d[SEG_W-1:0].
  - seg = lit ? pattern : 0.
  - seg_out = ACTIVE_LOW ? ~seg : seg.
- seg_out is registered. Latency: a write accepted at edge t updates the register; seg_out reflects it at edge t+1. Blink toggles appear at seg_out one cycle after blink_phase changes.
- Blink counter:
  - Runs 0..BLINK_DIV-1.
  - On wrap, the counter returns to 0 and blink_phase toggles.
  - Any CTRL write clears the counter and blink_phase in the same edge, so newly blinking digits start visible.
  - The counter runs continuously, independent of the masks.
- Reset, including mid-operation, asynchronously clears:
  - all DIGIT registers, the counter and blink_phase;
  - CTRL to its reset value;
  - seg_out to all-dark (all 1s if ACTIVE_LOW, else all 0s).
- Simultaneous CTRL write and counter wrap: the write wins (counter 0, phase 0).

Decomposition:
- Package seg_display_pkg holds:
  - register offset constants (CTRL_OFS = NUM_DIGITS, STATUS_OFS = NUM_DIGITS+1);
  - CTRL bit-field positions;
  - the 16-entry hex segment table.
- Sub-module seg_hex_decoder: pure combinational, nibble to 7-bit pattern, instantiated NUM_DIGITS times.

Test Plan:
- Reset release, NUM_DIGITS=6, ACTIVE_LOW=1 -> seg_out all 1s; readdata at CTRL = 0x10000; all DIGIT registers read 0.
- Write DIGIT[2]=0x06 in raw mode -> seg_out[20:14]=~0x06=0x79 at edge t+1; reading address 2 returns 0x00000006.
- Write CTRL=0x10003, then DIGIT[0]=0x8, DIGIT[1]=0xA -> digit0 drives ~0x7F=0x00 and digit1 drives ~0x77=0x08; address 9 reads 0 and a write there changes nothing.
- BLINK_DIV=4, write CTRL=0x10401 -> digit2 visible for 4 cycles, dark for 4, repeating; STATUS[0] tracks phase; a CTRL write timed on the wrap edge leaves phase 0.
- Write CTRL=0x00000 -> all digits dark; assert reset mid-blink -> seg_out all-dark asynchronously and the counter restarts from 0 after release.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the multi-digit 7-segment display controller:
// register offsets, CTRL field positions and the hex segment table.
package seg_display_pkg;

    // CTRL register field positions
    localparam int CTRL_DECODE_LSB  = 0;
    localparam int CTRL_BLINK_LSB   = 8;
    localparam int CTRL_ENABLE_BIT  = 16;
    localparam int CTRL_MASK_W      = 8;

    // STATUS register field positions
    localparam int STATUS_PHASE_BIT = 0;

    // Hex digit to segment pattern, bit0 = a ... bit6 = g, active-high
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // CTRL sits directly after the digit registers
    function automatic int ctrl_ofs(input int num_digits);
        return num_digits;
    endfunction

    // STATUS sits directly after CTRL
    function automatic int status_ofs(input int num_digits);
        return num_digits + 1;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_hex_decoder.sv
// Combinational nibble to 7-segment pattern lookup (active-high).
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_TABLE[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped multi-digit 7-segment display controller with per-digit
// raw/hex mode, per-digit blink, global enable and optional active-low drive.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_W      = 7,
    parameter int ADDR_W     = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
    output logic                        blink_phase
);

    localparam int                        OUT_W       = NUM_DIGITS * SEG_W;
    localparam logic [ADDR_W-1:0]         CTRL_ADDR   = ADDR_W'(ctrl_ofs(NUM_DIGITS));
    localparam logic [ADDR_W-1:0]         STATUS_ADDR = ADDR_W'(status_ofs(NUM_DIGITS));
    localparam int                        CNT_W       = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]          CNT_MAX     = CNT_W'(BLINK_DIV - 1);
    localparam logic [OUT_W-1:0]          DARK        = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [SEG_W-1:0]      digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] decode_mask;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic                  enable;
    logic [CNT_W-1:0]      blink_cnt;
    logic [OUT_W-1:0]      seg_next;
    logic                  wr;
    logic                  ctrl_wr;
    logic                  unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign ctrl_wr      = wr && (address == CTRL_ADDR);
    assign unused_wdata = ^writedata;

    // Register file: digit patterns and CTRL fields; unmapped writes fall through
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
            decode_mask <= '0;
            blink_mask  <= '0;
            enable      <= 1'b1;
        end else if (wr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == ADDR_W'(i)) begin
                    digit_reg[i] <= writedata[SEG_W-1:0];
                end
            end
            if (address == CTRL_ADDR) begin
                decode_mask <= writedata[CTRL_DECODE_LSB +: NUM_DIGITS];
                blink_mask  <= writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
                enable      <= writedata[CTRL_ENABLE_BIT];
            end
        end
    end

    // Blink prescaler; a CTRL write restarts it so newly blinking digits begin lit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (ctrl_wr) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Zero-wait-state read mux; mask bits above NUM_DIGITS read back as 0
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == ADDR_W'(i)) begin
                readdata = 32'(digit_reg[i]);
            end
        end
        if (address == CTRL_ADDR) begin
            readdata[CTRL_DECODE_LSB +: NUM_DIGITS] = decode_mask;
            readdata[CTRL_BLINK_LSB +: NUM_DIGITS]  = blink_mask;
            readdata[CTRL_ENABLE_BIT]               = enable;
        end
        if (address == STATUS_ADDR) begin
            readdata[STATUS_PHASE_BIT] = blink_phase;
        end
    end

    // Per-digit pixel logic producing the active-high pattern before polarity
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [6:0]       hex_pat;
        logic [SEG_W-1:0] pattern;
        logic             lit;

        seg_hex_decoder u_dec (
            .nibble  (digit_reg[g][3:0]),
            .pattern (hex_pat)
        );

        if (SEG_W == 8) begin : g_dp
            assign pattern = decode_mask[g] ? {digit_reg[g][4], hex_pat} : digit_reg[g];
        end else begin : g_nodp
            assign pattern = decode_mask[g] ? hex_pat : digit_reg[g];
        end

        assign lit = enable & ~(blink_mask[g] & blink_phase);
        assign seg_next[g*SEG_W +: SEG_W] = lit ? pattern : '0;
    end

    // Output register with polarity applied; reset forces every segment dark
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out <= DARK;
        end else begin
            seg_out <= ACTIVE_LOW ? ~seg_next : seg_next;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl (6 digits, fast blink).
module tb_seg_display_ctrl;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;
    localparam int ADDR_W     = 4;
    localparam int BLINK_DIV  = 4;
    localparam int OUT_W      = NUM_DIGITS * SEG_W;
    localparam logic [ADDR_W-1:0] CTRL_A   = 4'd6;
    localparam logic [ADDR_W-1:0] STATUS_A = 4'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [OUT_W-1:0]  seg_out;
    logic              blink_phase;

    int vectors     = 0;
    int miscompares = 0;

    seg_display_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEG_W      (SEG_W),
        .ADDR_W     (ADDR_W),
        .BLINK_DIV  (BLINK_DIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .seg_out     (seg_out),
        .blink_phase (blink_phase)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point: counts every vector and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus write, accepted at the next rising edge
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Side-effect-free read sampled mid low phase
    task automatic readCheck(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        @(negedge clk);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #2;
        checkOutput(tag, 64'(readdata), 64'(exp));
        chipselect = 1'b0;
    endtask

    function automatic logic [6:0] digitOf(input logic [OUT_W-1:0] s, input int i);
        return s[i*SEG_W +: SEG_W];
    endfunction

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #23;
        reset = 1'b0;
        tick();

        // Reset state
        checkOutput("reset_seg", 64'(seg_out), 64'({OUT_W{1'b1}}));
        readCheck("reset_ctrl", CTRL_A, 32'h0001_0000);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            readCheck($sformatf("reset_dig%0d", i), ADDR_W'(i), 32'h0);
        end

        // Raw write to digit 2 and its one-cycle output latency
        applyStimulus(4'd2, 32'h0000_0006);
        checkOutput("raw_lat_t", 64'(digitOf(seg_out, 2)), 64'h7F);
        tick();
        checkOutput("raw_dig2", 64'(digitOf(seg_out, 2)), 64'h79);
        checkOutput("raw_dig3", 64'(digitOf(seg_out, 3)), 64'h7F);
        readCheck("raw_read2", 4'd2, 32'h0000_0006);

        // Hex decode on digits 0 and 1
        applyStimulus(CTRL_A, 32'h0001_0003);
        applyStimulus(4'd0, 32'h0000_0008);
        applyStimulus(4'd1, 32'h0000_000A);
        tick();
        checkOutput("hex_dig0", 64'(digitOf(seg_out, 0)), 64'h00);
        checkOutput("hex_dig1", 64'(digitOf(seg_out, 1)), 64'h08);
        checkOutput("hex_dig2", 64'(digitOf(seg_out, 2)), 64'h79);

        // Unmapped address: reads 0, writes change nothing
        readCheck("unmapped_rd", 4'd9, 32'h0);
        applyStimulus(4'd9, 32'hFFFF_FFFF);
        tick();
        checkOutput("unmapped_seg", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h08, 7'h00}));
        readCheck("unmapped_ctrl", CTRL_A, 32'h0001_0003);
        readCheck("unmapped_dig0", 4'd0, 32'h0000_0008);

        // Mask bits beyond NUM_DIGITS are dropped
        applyStimulus(CTRL_A, 32'h0001_FFFF);
        readCheck("ctrl_trunc", CTRL_A, 32'h0001_3F3F);

        // Blink digit 2, decode digit 0: 4 cycles lit, 4 dark
        applyStimulus(CTRL_A, 32'h0001_0401);
        address    = STATUS_A;
        chipselect = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checkOutput($sformatf("blink_dig2_c%0d", i), 64'(digitOf(seg_out, 2)),
                        ((((i - 1) / 4) % 2) == 0) ? 64'h79 : 64'h7F);
            checkOutput($sformatf("blink_stat_c%0d", i), 64'(readdata), 64'(((i / 4) % 2)));
        end
        checkOutput("blink_dig1", 64'(digitOf(seg_out, 1)), 64'h75);
        repeat (7) tick();

        // CTRL write on the 0->1 wrap edge: write wins, phase stays 0
        applyStimulus(CTRL_A, 32'h0001_0401);
        address    = STATUS_A;
        chipselect = 1'b1;
        #1;
        checkOutput("wrap_wr_phase", 64'(readdata), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("wrap_after_c%0d", i), 64'(readdata), (i == 4) ? 64'h1 : 64'h0);
        end

        // Display disable darkens every digit
        applyStimulus(CTRL_A, 32'h0000_0000);
        tick();
        checkOutput("disable_seg", 64'(seg_out), 64'({OUT_W{1'b1}}));

        // Asynchronous reset mid-blink
        applyStimulus(CTRL_A, 32'h0001_0401);
        repeat (5) tick();
        checkOutput("pre_reset_dig1", 64'(digitOf(seg_out, 1)), 64'h75);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_seg", 64'(seg_out), 64'({OUT_W{1'b1}}));
        checkOutput("async_rst_phase", 64'(blink_phase), 64'h0);
        readCheck("async_rst_ctrl", CTRL_A, 32'h0001_0000);
        readCheck("async_rst_dig2", 4'd2, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        address    = STATUS_A;
        chipselect = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("restart_c%0d", i), 64'(readdata), (i == 4) ? 64'h1 : 64'h0);
        end
        chipselect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
